scan_decoder: RTL and testbench

- Parametrised, registered successor to the team's 3-input active-low 2-to-4 enable decoder.
- Decodes a SEL_W-bit select into 2^SEL_W one-hot/one-cold lines, with an active-low enable.
- Adds an autonomous scan mode: an internal counter walks every output with programmable dwell.
- Sits in front of display-digit and keypad-row drivers; replaces hand-instanced gate decoders.

---
 rtl/scan_decoder_pkg.sv | 18 +
 rtl/scan_decoder_onehot_decode.sv | 20 ++
 rtl/scan_decoder.sv | 107 ++++++++++
 tb/tb_scan_decoder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the registered select decoder with autonomous scan mode.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Level of a deasserted output line for the given polarity.
    function automatic logic inactive_level(input logic active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/scan_decoder_onehot_decode.sv
// Combinational SEL_W -> 2^SEL_W line decoder, one-hot or one-cold.
module onehot_decode #(
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic [SEL_W-1:0]        sel,
    output logic [(1<<SEL_W)-1:0]   dout
);

    localparam int unsigned N_OUT = 1 << SEL_W;

    logic [N_OUT-1:0] hot;

    always_comb begin
        hot      = '0;
        hot[sel] = 1'b1;
        dout     = (ACTIVE_LOW != 0) ? ~hot : hot;
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered decoder with active-low enable; scan mode walks every line with a
// programmable dwell per slot.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned DWELL_W    = 4,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [(1<<SEL_W)-1:0]   dout,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    valid,
    output logic                    wrap
);

    localparam int unsigned N_OUT = 1 << SEL_W;
    localparam logic        INACT = inactive_level(ACTIVE_LOW != 0);

    state_e               state_q;
    logic [SEL_W-1:0]     idx_q;
    logic [DWELL_W-1:0]   cnt_q;
    logic [DWELL_W-1:0]   dwell_q;

    logic                 slot_end;
    logic [SEL_W-1:0]     dec_sel;
    logic [N_OUT-1:0]     dec_out;

    // Index that the coming edge will present on dout.
    always_comb begin
        slot_end = (cnt_q == dwell_q);
        dec_sel  = sel;
        if (mode == MODE_SCAN) begin
            if (state_q != SCAN) begin
                dec_sel = '0;
            end else if (slot_end) begin
                dec_sel = idx_q + SEL_W'(1);
            end else begin
                dec_sel = idx_q;
            end
        end
    end

    onehot_decode #(
        .SEL_W      (SEL_W),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_decode (
        .sel  (dec_sel),
        .dout (dec_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            dout    <= {N_OUT{INACT}};
            cur_sel <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
        end else if (en_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            dout    <= {N_OUT{INACT}};
            cur_sel <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            dout    <= dec_out;
            cur_sel <= dec_sel;
            valid   <= 1'b1;
            if (mode == MODE_DIRECT) begin
                state_q <= DIRECT;
                idx_q   <= '0;
                cnt_q   <= '0;
                wrap    <= 1'b0;
            end else if (state_q != SCAN) begin
                state_q <= SCAN;
                idx_q   <= '0;
                cnt_q   <= '0;
                dwell_q <= dwell;
                wrap    <= 1'b0;
            end else if (slot_end) begin
                idx_q   <= dec_sel;
                cnt_q   <= '0;
                dwell_q <= dwell;
                wrap    <= &idx_q;
            end else begin
                cnt_q   <= cnt_q + DWELL_W'(1);
                wrap    <= 1'b0;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        $countones(dout ^ {N_OUT{INACT}}) <= 1);
    assert property (@(posedge clk) disable iff (!rst_n)
        valid |-> $onehot(dout ^ {N_OUT{INACT}}));

endmodule

// File: tb/tb_scan_decoder.sv
// Directed-vector bench for scan_decoder at SEL_W=2, DWELL_W=4, ACTIVE_LOW=1.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_n;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] dwell;
    logic [3:0] dout;
    logic [1:0] cur_sel;
    logic       valid;
    logic       wrap;

    int n_checks = 0;
    int n_pass   = 0;

    scan_decoder #(
        .SEL_W      (2),
        .DWELL_W    (4),
        .ACTIVE_LOW (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_n    (en_n),
        .mode    (mode),
        .sel     (sel),
        .dwell   (dwell),
        .dout    (dout),
        .cur_sel (cur_sel),
        .valid   (valid),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] cold(input int i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return ~v;
    endfunction

    task automatic check_scan(input string tag, input int idx, input logic exp_wrap);
        check({tag, " dout"}, dout, cold(idx));
        check({tag, " cur_sel"}, cur_sel, idx);
        check({tag, " valid"}, valid, 1'b1);
        check({tag, " wrap"}, wrap, exp_wrap);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " dout"}, dout, 4'b1111);
        check({tag, " valid"}, valid, 1'b0);
        check({tag, " wrap"}, wrap, 1'b0);
    endtask

    int seq_fast [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    int seq_slow [9] = '{0, 0, 0, 1, 1, 1, 2, 3, 0};

    initial begin
        rst_n = 1'b0; en_n = 1'b0; mode = 1'b1; sel = 2'd3; dwell = 4'd5;
        step(); step();
        check_idle("reset");
        check("reset cur_sel", cur_sel, 0);

        // Direct decode, one cycle latency.
        rst_n = 1'b1; mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            step();
            check_scan($sformatf("direct%0d", i), i, 1'b0);
        end

        // Scan, dwell 0: wrap on the 5th and 9th output cycle.
        mode = 1'b1; dwell = 4'd0;
        for (int k = 0; k < 9; k++) begin
            step();
            check_scan($sformatf("fast%0d", k), seq_fast[k], (k == 4) || (k == 8));
        end

        en_n = 1'b1;
        step();
        check_idle("idle_gap");

        // Scan, dwell 2; dwell dropped to 0 one cycle into slot 1.
        en_n = 1'b0; dwell = 4'd2;
        for (int k = 0; k < 9; k++) begin
            if (k == 4) dwell = 4'd0;
            step();
            check_scan($sformatf("slow%0d", k), seq_slow[k], k == 8);
        end

        // Disable at index 2, then resume from 0.
        step();
        check_scan("pre_dis1", 1, 1'b0);
        step();
        check_scan("pre_dis2", 2, 1'b0);
        en_n = 1'b1;
        step();
        check_idle("disable");
        en_n = 1'b0;
        step();
        check_scan("resume", 0, 1'b0);

        // Reset on the slot-end edge leaving index 3.
        step(); step(); step();
        check_scan("pre_rst", 3, 1'b0);
        rst_n = 1'b0;
        step();
        check_idle("rst_slot_end");
        check("rst_slot_end cur_sel", cur_sel, 0);
        rst_n = 1'b1;
        step();
        check_scan("post_rst0", 0, 1'b0);
        step();
        check_scan("post_rst1", 1, 1'b0);

        // Scan -> direct switches on the next edge.
        mode = 1'b0; sel = 2'd2;
        step();
        check_scan("to_direct", 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
